mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one downstream memory port between the instruction
// fetch (I) and data (D) requesters. Only one transaction is outstanding
// at a time; simultaneous requests are resolved round-robin.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,

    // instruction fetch requester
    input  logic                  i_valid,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_addr_ok,
    output logic                  i_data_ok,
    output logic [DATA_W-1:0]     i_data,

    // data requester
    input  logic                  d_valid,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [2:0]            d_size,
    input  logic [DATA_W/8-1:0]   d_strobe,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_addr_ok,
    output logic                  d_data_ok,
    output logic [DATA_W-1:0]     d_rdata,

    // downstream memory port
    output logic                  m_valid,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [2:0]            m_size,
    output logic [DATA_W/8-1:0]   m_strobe,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic                  m_addr_ok,
    input  logic                  m_data_ok,
    input  logic [DATA_W-1:0]     m_rdata
);

    localparam int STRB_W = DATA_W / 8;

    // owner / last_grant encoding
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t              state;
    logic                owner;
    logic                last_grant;

    // request captured at grant time; drives the memory port through REQ
    logic [ADDR_W-1:0]   buf_addr;
    logic [2:0]          buf_size;
    logic [STRB_W-1:0]   buf_strobe;
    logic [DATA_W-1:0]   buf_wdata;

    logic                idle;
    logic                pick_d;
    logic                grant_i;
    logic                grant_d;
    logic                done;

    // Grant decision: a lone requester wins; on a tie the one that did not
    // win last time is served. Outputs are held low while reset is asserted.
    always_comb begin
        idle    = resetn && (state == IDLE);
        pick_d  = d_valid && (!i_valid || (last_grant == OWN_I));
        grant_d = idle && pick_d;
        grant_i = idle && i_valid && !pick_d;
    end

    // Completion: response accepted together with the address in REQ, or
    // any response in WAIT. Responses in IDLE or in REQ without addr_ok are
    // not ours and are dropped.
    always_comb begin
        done = resetn && (((state == REQ) && m_addr_ok && m_data_ok) ||
                          ((state == WAIT) && m_data_ok));
    end

    // Transaction FSM, owner tracking and request buffering.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            owner      <= OWN_I;
            last_grant <= OWN_I;
            buf_addr   <= '0;
            buf_size   <= '0;
            buf_strobe <= '0;
            buf_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        owner      <= OWN_D;
                        last_grant <= OWN_D;
                        buf_addr   <= d_addr;
                        buf_size   <= d_size;
                        buf_strobe <= d_strobe;
                        buf_wdata  <= d_wdata;
                        state      <= REQ;
                    end else if (grant_i) begin
                        // fetches are always word reads
                        owner      <= OWN_I;
                        last_grant <= OWN_I;
                        buf_addr   <= i_addr;
                        buf_size   <= 3'd2;
                        buf_strobe <= '0;
                        buf_wdata  <= '0;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (m_addr_ok) begin
                        state <= m_data_ok ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (m_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Requester handshakes and response routing to the current owner.
    always_comb begin
        i_addr_ok = grant_i;
        d_addr_ok = grant_d;
        i_data_ok = done && (owner == OWN_I);
        d_data_ok = done && (owner == OWN_D);
        i_data    = i_data_ok ? m_rdata : '0;
        d_rdata   = d_data_ok ? m_rdata : '0;
    end

    // Downstream request, presented only while in REQ.
    always_comb begin
        m_valid  = resetn && (state == REQ);
        m_addr   = buf_addr;
        m_size   = buf_size;
        m_strobe = buf_strobe;
        m_wdata  = buf_wdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors with hand-computed expectations for the
// I/D memory arbiter.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk;
    logic              resetn;
    logic              i_valid;
    logic [ADDR_W-1:0] i_addr;
    logic              i_addr_ok, i_data_ok;
    logic [DATA_W-1:0] i_data;
    logic              d_valid;
    logic [ADDR_W-1:0] d_addr;
    logic [2:0]        d_size;
    logic [3:0]        d_strobe;
    logic [DATA_W-1:0] d_wdata;
    logic              d_addr_ok, d_data_ok;
    logic [DATA_W-1:0] d_rdata;
    logic              m_valid;
    logic [ADDR_W-1:0] m_addr;
    logic [2:0]        m_size;
    logic [3:0]        m_strobe;
    logic [DATA_W-1:0] m_wdata;
    logic              m_addr_ok, m_data_ok;
    logic [DATA_W-1:0] m_rdata;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .resetn(resetn),
        .i_valid(i_valid), .i_addr(i_addr),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_data(i_data),
        .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size),
        .d_strobe(d_strobe), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size),
        .m_strobe(m_strobe), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // single comparison point for the whole bench
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge; inputs are then driven
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // let combinational outputs settle before sampling
    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        i_valid = 0; i_addr = '0;
        d_valid = 0; d_addr = '0; d_size = '0; d_strobe = '0; d_wdata = '0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
    endtask

    task automatic do_reset();
        resetn = 0;
        idle_inputs();
        tick();
        tick();
        resetn = 1;
    endtask

    initial begin
        resetn = 0;
        idle_inputs();

        // ---- reset state: outputs quiet even with requests pending
        tick();
        i_valid = 1; d_valid = 1; m_data_ok = 1; m_addr_ok = 1;
        settle();
        chk("rst_i_addr_ok", i_addr_ok, 0);
        chk("rst_d_addr_ok", d_addr_ok, 0);
        chk("rst_m_valid",   m_valid,   0);
        chk("rst_data_ok",   {i_data_ok, d_data_ok}, 0);
        chk("rst_m_addr",    m_addr,    0);
        tick();
        idle_inputs();
        resetn = 1;

        // ---- tie after reset: D wins, then I in the next IDLE cycle
        i_valid = 1; i_addr = 32'h0000_0200;
        d_valid = 1; d_addr = 32'h0000_0100; d_size = 3'd2;
        settle();
        chk("tie_d_addr_ok", d_addr_ok, 1);
        chk("tie_i_addr_ok", i_addr_ok, 0);
        tick();
        d_valid = 0;
        m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'hAAAA_5555;
        settle();
        chk("tie_m_valid",   m_valid,   1);
        chk("tie_m_addr",    m_addr,    32'h0000_0100);
        chk("tie_i_held",    i_addr_ok, 0);
        chk("tie_d_data_ok", d_data_ok, 1);
        chk("tie_d_rdata",   d_rdata,   32'hAAAA_5555);
        chk("tie_i_data_ok", i_data_ok, 0);
        chk("tie_i_data_0",  i_data,    0);
        tick();
        m_addr_ok = 0; m_data_ok = 0;
        settle();
        chk("tie_m_valid_idle", m_valid,  0);
        chk("tie_i_granted",    i_addr_ok, 1);
        tick();
        i_valid = 0;
        m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h1111_2222;
        settle();
        chk("tie_i_m_addr",  m_addr,    32'h0000_0200);
        chk("tie_i_data_ok", i_data_ok, 1);
        chk("tie_i_data",    i_data,    32'h1111_2222);
        chk("tie_d_quiet",   d_data_ok, 0);
        tick();
        idle_inputs();

        // ---- fetch with addr_ok at once, response two cycles later
        i_valid = 1; i_addr = 32'hBFC0_0000;
        settle();
        chk("if_addr_ok", i_addr_ok, 1);
        tick();
        i_valid = 0; m_addr_ok = 1;
        settle();
        chk("if_m_valid",  m_valid,  1);
        chk("if_m_addr",   m_addr,   32'hBFC0_0000);
        chk("if_m_strobe", m_strobe, 0);
        chk("if_m_size",   m_size,   2);
        chk("if_no_resp",  i_data_ok, 0);
        tick();
        m_addr_ok = 0;
        settle();
        chk("if_wait_m_valid", m_valid,  0);
        chk("if_wait_no_resp", i_data_ok, 0);
        tick();
        m_data_ok = 1; m_rdata = 32'h3C1D_0000;
        settle();
        chk("if_data_ok", i_data_ok, 1);
        chk("if_data",    i_data,    32'h3C1D_0000);
        tick();
        m_data_ok = 0;
        settle();
        chk("if_data_ok_drop", i_data_ok, 0);
        chk("if_data_zero",    i_data,    0);
        idle_inputs();

        // ---- D write stalled 3 cycles by m_addr_ok; stray data_ok in REQ ignored
        d_valid = 1; d_addr = 32'h8000_0010; d_size = 3'd1;
        d_strobe = 4'b0011; d_wdata = 32'h1234_5678;
        settle();
        chk("wr_addr_ok", d_addr_ok, 1);
        tick();
        d_valid = 0; d_addr = '0; d_strobe = '0; d_wdata = '0;
        for (int k = 0; k < 4; k++) begin
            m_addr_ok = (k == 3);
            m_data_ok = (k == 1);
            settle();
            chk("wr_m_valid",  m_valid,  1);
            chk("wr_m_addr",   m_addr,   32'h8000_0010);
            chk("wr_m_strobe", m_strobe, 4'b0011);
            chk("wr_m_wdata",  m_wdata,  32'h1234_5678);
            chk("wr_m_size",   m_size,   1);
            chk("wr_no_resp",  d_data_ok, 0);
            tick();
        end
        m_addr_ok = 0; m_data_ok = 0;
        settle();
        chk("wr_wait_m_valid", m_valid, 0);
        chk("wr_wait_no_resp", d_data_ok, 0);
        tick();
        m_data_ok = 1; m_rdata = 32'h0BAD_F00D;
        settle();
        chk("wr_d_data_ok", d_data_ok, 1);
        chk("wr_i_quiet",   i_data_ok, 0);
        tick();
        idle_inputs();

        // ---- both always valid, zero latency memory: D,I,D,I,D,I
        do_reset();
        i_valid = 1; i_addr = 32'h0000_1000;
        d_valid = 1; d_addr = 32'h0000_2000; d_size = 3'd2;
        m_addr_ok = 1; m_data_ok = 1;
        for (int k = 0; k < 6; k++) begin
            m_rdata = 32'hDEAD_0000 + k;
            settle();
            chk("rr_d_addr_ok", d_addr_ok, (k % 2) == 0);
            chk("rr_i_addr_ok", i_addr_ok, (k % 2) == 1);
            chk("rr_idle_no_resp", {i_data_ok, d_data_ok}, 0);
            tick();
            settle();
            chk("rr_m_addr",    m_addr, ((k % 2) == 0) ? 32'h0000_2000 : 32'h0000_1000);
            chk("rr_req_no_grant", {i_addr_ok, d_addr_ok}, 0);
            chk("rr_d_data_ok", d_data_ok, (k % 2) == 0);
            chk("rr_i_data_ok", i_data_ok, (k % 2) == 1);
            tick();
        end
        idle_inputs();

        // ---- reset during WAIT abandons the transaction
        do_reset();
        i_valid = 1; i_addr = 32'h0000_3000;
        settle();
        chk("rw_grant", i_addr_ok, 1);
        tick();
        i_valid = 0; m_addr_ok = 1;
        tick();
        m_addr_ok = 0;
        resetn = 0; m_data_ok = 1; m_rdata = 32'h5555_AAAA;
        settle();
        chk("rw_in_rst_resp",  {i_data_ok, d_data_ok}, 0);
        chk("rw_in_rst_mvld",  m_valid, 0);
        tick();
        resetn = 1;
        settle();
        chk("rw_late_resp",    {i_data_ok, d_data_ok}, 0);
        chk("rw_late_i_data",  i_data, 0);
        chk("rw_m_valid",      m_valid, 0);
        tick();
        m_data_ok = 0;
        i_valid = 1; i_addr = 32'h0000_4000;
        settle();
        chk("rw_idle_regrant", i_addr_ok, 1);
        tick();
        i_valid = 0;
        settle();
        chk("rw_regrant_addr", m_addr, 32'h0000_4000);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
